// File: rtl/alu_issue_ctrl.sv
// +-----------------------------------------------------------------------------+
// | alu_issue_ctrl: issue/collect stage feeding the ALU AddSub unit.             |
// | Optional stall counter output guarded by ALU_ISSUE_STALLCNT_EN. Rev 1.0      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module alu_issue_ctrl #(
  parameter int LATENCY = 1,
  parameter int OPW     = 5
) (
  input  logic            soc_clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [OPW-1:0]  op_code,
  input  logic [31:0]     op_a,
  input  logic [31:0]     op_b,
  output logic [31:0]     ALU_dat1,
  output logic [31:0]     ALU_dat2,
  output logic [OPW-1:0]  Instruction_to_ALU,
  output logic            dat_ready,
  input  logic [31:0]     alu_result,
  input  logic            alu_overflow,
  input  logic            alu_zero,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_data,
  output logic            res_overflow,
  output logic            res_zero
`ifdef ALU_ISSUE_STALLCNT_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range
    $error("alu_issue_ctrl: LATENCY must lie within 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  code_q, code_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rovf_q, rovf_d;
  logic            rzero_q, rzero_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rovf_d  = rovf_q;
    rzero_d = rzero_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          code_d  = op_code;
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Counter reaching zero marks the last cycle the ALU output is valid.
        if (cnt_q == 4'd0) begin
          rdata_d = alu_result;
          rovf_d  = alu_overflow;
          rzero_d = alu_zero;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rovf_q  <= 1'b0;
      rzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rovf_q  <= rovf_d;
      rzero_q <= rzero_d;
    end
  end

  always_comb begin
    op_ready           = 1'b0;
    dat_ready          = 1'b0;
    res_valid          = 1'b0;
    ALU_dat1           = '0;
    ALU_dat2           = '0;
    Instruction_to_ALU = '0;
    if (state_q == S_ISSUE) begin
      ALU_dat1           = a_q;
      ALU_dat2           = b_q;
      Instruction_to_ALU = code_q;
    end
    // Handshake outputs are suppressed while reset is asserted.
    if (!reset) begin
      op_ready  = (state_q == S_IDLE);
      dat_ready = (state_q == S_ISSUE);
      res_valid = (state_q == S_RESP);
    end
  end

  assign res_data     = rdata_q;
  assign res_overflow = rovf_q;
  assign res_zero     = rzero_q;

`ifdef ALU_ISSUE_STALLCNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_RESP && !res_ready && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

`default_nettype wire
